// File: rtl/cam_lutram_multi.sv
// Multi-entry LUTRAM CAM: one 32x1 column per (pack, entry) holds a one-hot key pack,
// and a lookup ANDs the per-pack row bits of each valid entry into a hit vector.
module cam_lutram_multi #(
    parameter int  PACKS_OF_5_BITS = 4,
    parameter int  ENTRIES         = 8,
    localparam int IW              = $clog2(ENTRIES)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_inv_i,
    input  logic [IW-1:0]                   cmd_idx_i,
    input  logic [PACKS_OF_5_BITS-1:0][4:0] cmd_key_i,
    input  logic [PACKS_OF_5_BITS-1:0][4:0] cmp_key_i,
    output logic [ENTRIES-1:0]              hit_vec_o,
    output logic                            hit_o,
    output logic [IW-1:0]                   hit_idx_o,
    output logic                            multi_hit_o,
    output logic [PACKS_OF_5_BITS-1:0][4:0] hit_key_o
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR, ST_SET} state_e;
    typedef logic [PACKS_OF_5_BITS-1:0][4:0] key_t;

    state_e               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [ENTRIES-1:0]   valid_q, valid_d;
    key_t                 key_q [ENTRIES];
    key_t                 key_d [ENTRIES];
    logic [IW-1:0]        pend_idx_q, pend_idx_d;
    key_t                 pend_key_q, pend_key_d;
    logic                 pend_inv_q, pend_inv_d;

    logic [ENTRIES-1:0]   wr_en;
    key_t                 wr_addr;
    logic                 wr_bit;

    logic [31:0]          col_mem [PACKS_OF_5_BITS][ENTRIES];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            valid_q    <= '0;
            pend_idx_q <= '0;
            pend_key_q <= '0;
            pend_inv_q <= 1'b0;
            for (int e = 0; e < ENTRIES; e++) key_q[e] <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only,
            // so every flop samples the pre-edge value of every other flop.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            pend_idx_q <= pend_idx_d;
            pend_key_q <= pend_key_d;
            pend_inv_q <= pend_inv_d;
            for (int e = 0; e < ENTRIES; e++) key_q[e] <= key_d[e];
        end
    end

    // Next-state and register next-values
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        pend_idx_d = pend_idx_q;
        pend_key_d = pend_key_q;
        pend_inv_d = pend_inv_q;
        for (int e = 0; e < ENTRIES; e++) key_d[e] = key_q[e];

        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    pend_idx_d         = cmd_idx_i;
                    pend_key_d         = cmd_key_i;
                    pend_inv_d         = cmd_inv_i;
                    valid_d[cmd_idx_i] = 1'b0;
                    // Invalid entries already have all-zero rows, so CLEAR is skipped.
                    if (valid_q[cmd_idx_i]) state_d = ST_CLEAR;
                    else if (!cmd_inv_i)    state_d = ST_SET;
                end
            end
            ST_CLEAR: state_d = pend_inv_q ? ST_IDLE : ST_SET;
            ST_SET: begin
                key_d[pend_idx_q]   = pend_key_q;
                valid_d[pend_idx_q] = 1'b1;
                state_d             = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State-decoded outputs and column write controls
    always_comb begin
        cmd_ready_o = 1'b0;
        wr_en       = '0;
        wr_addr     = '0;
        wr_bit      = 1'b0;
        case (state_q)
            ST_INIT: begin
                wr_en = '1;
                for (int p = 0; p < PACKS_OF_5_BITS; p++) wr_addr[p] = cnt_q;
            end
            ST_IDLE: cmd_ready_o = 1'b1;
            ST_CLEAR: begin
                wr_en[pend_idx_q] = 1'b1;
                wr_addr           = key_q[pend_idx_q];
            end
            ST_SET: begin
                wr_en[pend_idx_q] = 1'b1;
                wr_addr           = pend_key_q;
                wr_bit            = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: the LUTRAM columns carry no reset; the INIT sweep clears them instead,
    // which keeps them mappable onto distributed RAM.
    always_ff @(posedge clk) begin
        for (int p = 0; p < PACKS_OF_5_BITS; p++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (rst_n && wr_en[e]) col_mem[p][e][wr_addr[p]] <= wr_bit;
            end
        end
    end

    // Lookup: asynchronous column reads, ANDed across packs and gated by valid
    always_comb begin
        logic match;
        hit_vec_o = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            match = valid_q[e];
            for (int p = 0; p < PACKS_OF_5_BITS; p++) begin
                match = match & col_mem[p][e][cmp_key_i[p]];
            end
            hit_vec_o[e] = match;
        end
    end

    always_comb begin
        hit_idx_o = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (hit_vec_o[e]) hit_idx_o = IW'(e);
        end
    end

    assign hit_o       = |hit_vec_o;
    assign multi_hit_o = |(hit_vec_o & (hit_vec_o - {{(ENTRIES-1){1'b0}}, 1'b1}));
    assign hit_key_o   = key_q[hit_idx_o];

endmodule

// File: tb/tb_cam_lutram_multi.sv
// Directed bench for cam_lutram_multi: init sweep, update/re-update, multi-hit,
// invalidate, lookups during busy windows, and reset in the middle of a command.
module tb_cam_lutram_multi;

    localparam int P  = 4;
    localparam int E  = 8;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready_o;
    logic              cmd_inv;
    logic [IW-1:0]     cmd_idx;
    logic [P-1:0][4:0] cmd_key;
    logic [P-1:0][4:0] cmp_key;
    logic [E-1:0]      hit_vec_o;
    logic              hit_o;
    logic [IW-1:0]     hit_idx_o;
    logic              multi_hit_o;
    logic [P-1:0][4:0] hit_key_o;

    int total = 0;
    int bad   = 0;
    int low;

    cam_lutram_multi #(.PACKS_OF_5_BITS(P), .ENTRIES(E)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_inv_i   (cmd_inv),
        .cmd_idx_i   (cmd_idx),
        .cmd_key_i   (cmd_key),
        .cmp_key_i   (cmp_key),
        .hit_vec_o   (hit_vec_o),
        .hit_o       (hit_o),
        .hit_idx_o   (hit_idx_o),
        .multi_hit_o (multi_hit_o),
        .hit_key_o   (hit_key_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmp(input logic [19:0] k);
        cmp_key = k;
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready_o && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
    endtask

    task automatic issue(input logic inv, input logic [IW-1:0] idx, input logic [19:0] key);
        cmd_valid = 1'b1;
        cmd_inv   = inv;
        cmd_idx   = idx;
        cmd_key   = key;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_inv   = 1'b0;
        cmd_idx   = '0;
        cmd_key   = '0;
        cmp_key   = '0;
        tick();
        tick();
        check("rst_ready",   32'(cmd_ready_o), 32'd0);
        check("rst_hit_vec", 32'(hit_vec_o),   32'h0);
        check("rst_hit",     32'(hit_o),       32'd0);
        check("rst_hit_idx", 32'(hit_idx_o),   32'd0);
        check("rst_multi",   32'(multi_hit_o), 32'd0);
        check("rst_hit_key", 32'(hit_key_o),   32'h0);

        // Init sweep: ready stays low for exactly 32 cycles after release
        rst_n = 1'b1;
        low   = 0;
        for (int i = 0; i < 40; i++) begin
            if (!cmd_ready_o) low++;
            tick();
        end
        check("init_len", low, 32'd32);
        set_cmp(20'h00000);
        check("init_miss_zero", 32'(hit_o), 32'd0);
        set_cmp(20'hFFFFF);
        check("init_miss_ones", 32'(hit_o), 32'd0);

        // Update of an invalid entry: SET only
        set_cmp(20'h12345);
        issue(1'b0, 3'd3, 20'h12345);
        check("upd3_busy",     32'(cmd_ready_o), 32'd0);
        check("upd3_busy_hit", 32'(hit_vec_o),   32'h0);
        tick();
        check("upd3_ready",    32'(cmd_ready_o), 32'd1);
        check("upd3_hit_vec",  32'(hit_vec_o),   32'h08);
        check("upd3_hit_idx",  32'(hit_idx_o),   32'd3);
        check("upd3_hit_key",  32'(hit_key_o),   32'h12345);
        check("upd3_multi",    32'(multi_hit_o), 32'd0);
        set_cmp(20'h12344);
        check("upd3_near_miss", 32'(hit_o), 32'd0);

        // Re-update of a valid entry: CLEAR then SET, two busy cycles
        set_cmp(20'h12345);
        issue(1'b0, 3'd3, 20'hABCDE);
        low = 0;
        if (!cmd_ready_o) low++;
        check("reupd_clear_old", 32'(hit_vec_o), 32'h0);
        set_cmp(20'hABCDE);
        check("reupd_clear_new", 32'(hit_vec_o), 32'h0);
        tick();
        if (!cmd_ready_o) low++;
        check("reupd_set_new", 32'(hit_vec_o), 32'h0);
        set_cmp(20'h12345);
        check("reupd_set_old", 32'(hit_vec_o), 32'h0);
        tick();
        check("reupd_ready",    32'(cmd_ready_o), 32'd1);
        check("reupd_busy_len", low,              32'd2);
        check("reupd_old_miss", 32'(hit_o),       32'd0);
        set_cmp(20'hABCDE);
        check("reupd_hit_vec",  32'(hit_vec_o),   32'h08);
        check("reupd_hit_idx",  32'(hit_idx_o),   32'd3);
        check("reupd_hit_key",  32'(hit_key_o),   32'hABCDE);

        // Duplicate keys: lowest index wins, multi-hit flagged
        issue(1'b0, 3'd2, 20'h0F0F0);
        wait_ready("dup2");
        issue(1'b0, 3'd5, 20'h0F0F0);
        wait_ready("dup5");
        set_cmp(20'h0F0F0);
        check("dup_hit_vec", 32'(hit_vec_o),   32'h24);
        check("dup_hit_idx", 32'(hit_idx_o),   32'd2);
        check("dup_multi",   32'(multi_hit_o), 32'd1);
        check("dup_hit",     32'(hit_o),       32'd1);

        // Invalidate of a valid entry: one CLEAR cycle
        issue(1'b1, 3'd2, 20'h00000);
        check("inv2_busy",    32'(cmd_ready_o), 32'd0);
        check("inv2_busy_hv", 32'(hit_vec_o),   32'h20);
        tick();
        check("inv2_ready",   32'(cmd_ready_o), 32'd1);
        check("inv2_hit_vec", 32'(hit_vec_o),   32'h20);
        check("inv2_multi",   32'(multi_hit_o), 32'd0);
        check("inv2_hit_idx", 32'(hit_idx_o),   32'd5);
        check("inv2_hit_key", 32'(hit_key_o),   32'h0F0F0);

        // Invalidate of an invalid entry: no busy cycle
        issue(1'b1, 3'd6, 20'h00000);
        check("inv6_no_busy", 32'(cmd_ready_o), 32'd1);

        // Lookups of other entries stay correct while entry 7 is written
        issue(1'b0, 3'd0, 20'h11111);
        wait_ready("upd0");
        set_cmp(20'h11111);
        issue(1'b0, 3'd7, 20'h22222);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bg_hold_%0d", i), 32'(hit_vec_o), 32'h01);
            tick();
        end
        check("upd7_ready", 32'(cmd_ready_o), 32'd1);
        set_cmp(20'h22222);
        check("upd7_hit_vec", 32'(hit_vec_o), 32'h80);
        check("upd7_hit_idx", 32'(hit_idx_o), 32'd7);

        // Reset during SET of an update aborts it and wipes all entries
        issue(1'b0, 3'd7, 20'h33333);
        tick();
        check("abort_in_set", 32'(cmd_ready_o), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_rst_hv", 32'(hit_vec_o), 32'h0);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (!cmd_ready_o) low++;
            tick();
        end
        check("reinit_len", low, 32'd32);
        set_cmp(20'h33333);
        check("abort_pend_miss", 32'(hit_vec_o), 32'h0);
        set_cmp(20'h22222);
        check("abort_old7_miss", 32'(hit_vec_o), 32'h0);
        set_cmp(20'h11111);
        check("abort_e0_miss", 32'(hit_vec_o), 32'h0);
        tick();
        set_cmp(20'h0F0F0);
        check("abort_e5_miss", 32'(hit_vec_o), 32'h0);
        set_cmp(20'hABCDE);
        check("abort_e3_miss", 32'(hit_vec_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_lutram_multi.md
# cam_lutram_multi

Multi-entry content-addressable match array built from 32x1 LUTRAM columns: each key of `PACKS_OF_5_BITS` 5-bit packs is stored one-hot per pack, and a lookup ANDs the per-pack row bits to give a per-entry hit vector. It generalises the single-entry LUTRAM compare cell to `ENTRIES` independent entries. It adds per-entry valid bits, a command port for update and invalidate with ready/valid handshaking, a post-reset LUTRAM clear sweep, and priority encoding with multi-hit detection. It sits in front of TLB and BTB tag stores as the associative lookup stage.

## Interface
- `PACKS_OF_5_BITS`, 4, number of 5-bit key packs; key width = 5*PACKS_OF_5_BITS.
- `ENTRIES`, 8, number of entries (>=2); IW = $clog2(ENTRIES).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cmd_valid_i`  in  1  command request.
- `cmd_ready_o`  out  1  block can accept a command this cycle.
- `cmd_inv_i`  in  1  0 = update entry, 1 = invalidate entry.
- `cmd_idx_i`  in  IW  target entry.
- `cmd_key_i`  in  [PACKS_OF_5_BITS-1:0][4:0]  new key (ignored for invalidate).
- `cmp_key_i`  in  [PACKS_OF_5_BITS-1:0][4:0]  lookup key.
- `hit_vec_o`  out  ENTRIES  per-entry match, gated by valid.
- `hit_o`  out  1  OR of hit_vec_o.
- `hit_idx_o`  out  IW  lowest set index of hit_vec_o; 0 when no hit.
- `multi_hit_o`  out  1  more than one bit of hit_vec_o set.
- `hit_key_o`  out  [PACKS_OF_5_BITS-1:0][4:0]  stored key of entry hit_idx_o.

## Operation
- Storage per pack p and entry e: one 32x1 LUTRAM column, asynchronous read at cmp_key_i[p], synchronous write with a single write address and bit; row[p][e] = 1 means entry e's pack p equals that address.
- Registers: valid[ENTRIES], key_q[ENTRIES] (currently programmed key), pend_idx, pend_key, pend_inv, init counter (5 bits).
- hit_vec_o[e] = valid[e] & AND over p of row[p][e]; this is purely combinational from cmp_key_i.
- FSM states:
  - INIT: all columns write 0 at address = counter; counter 0..31; leave to IDLE after the write at 31.
  - IDLE: cmd_ready_o=1. On accept, latch pend_* and clear valid[cmd_idx_i]. Go to CLEAR if the entry was valid. Otherwise go to SET for an update, or stay in IDLE for an invalidate.
  - CLEAR: column pend_idx of every pack writes 0 at key_q[pend_idx][p]. Then go to IDLE if pend_inv, else to SET.
  - SET: column pend_idx of every pack writes 1 at pend_key[p]. Load key_q[pend_idx] = pend_key and set valid[pend_idx]. Then go to IDLE.
- Invariant: the rows of an invalid entry are all 0, so CLEAR is skipped for invalid entries.
- Only column pend_idx is write-enabled in CLEAR and SET; other entries are untouched.
- Several valid entries with the same key are legal: hit_idx_o is the lowest index and multi_hit_o = 1.

## Timing
- Reset (rst_n low at an edge):
  - Next state INIT, counter 0, valid all 0, key_q all 0.
  - cmd_ready_o=0, hit_vec_o=0, hit_o=0, hit_idx_o=0, multi_hit_o=0, hit_key_o=0.
- Reset asserted mid-command aborts the command. The full INIT sweep reruns, and no entry survives.
- INIT lasts 32 cycles after reset release; cmd_ready_o rises in the 33rd cycle.
- Handshake: a command is accepted at an edge where cmd_valid_i & cmd_ready_o. cmd_ready_o is 0 in INIT, CLEAR and SET. It depends only on state, never on cmd_valid_i.
- The target entry stops hitting from the cycle after acceptance.
- Update of a valid entry, accepted at edge E0:
  - CLEAR in cycle E0..E1, SET in cycle E1..E2.
  - The new key hits from the cycle after E2, and cmd_ready_o=1 in that same cycle.
- Update of an invalid entry: SET only; the new key hits and cmd_ready_o=1 two cycles after acceptance.
- Invalidate of a valid entry: CLEAR only, one busy cycle. Invalidate of an invalid entry: zero busy cycles.
- Lookups continue during CLEAR and SET; entries other than pend_idx return correct results throughout.

## Test plan
- Reset then idle 40 cycles: cmd_ready_o low for exactly 32 cycles. Lookups of cmp_key 0x00000 and 0xFFFFF then give hit_o=0.
- Update entry 3 with key 0x12345, then compare 0x12345: hit_vec_o=0x08, hit_idx_o=3, hit_key_o=0x12345. A compare with 0x12344 gives hit_o=0.
- Re-update entry 3 from 0x12345 to 0xABCDE: cmd_ready_o low for 2 cycles. 0x12345 then misses and 0xABCDE hits entry 3. No hit is seen on entry 3 during the busy window.
- Update entries 2 and 5 with 0x0F0F0: hit_vec_o=0x24, hit_idx_o=2, multi_hit_o=1. Invalidate entry 2: hit_vec_o=0x20, multi_hit_o=0.
- Hold cmp_key_i=0x11111, which matches entry 0, while entry 7 is updated to 0x22222: hit_vec_o stays 0x01 every cycle.
- Assert rst_n low during SET of an update: after re-INIT all valid=0 and the pending key does not hit.
